// File: rtl/instr_fetch.sv
// Instruction fetch front end: owns the PC, issues in-order imem reads, buffers two words, flushes on redirect.
// Define FETCH_PERF_EN to add the fetch/flush performance counter ports.
module instr_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_pc_sel,
    input  logic [31:0] i_alu_data,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_four,
    output logic        o_instr_vld,
    input  logic        i_instr_rdy,
    output logic        o_misalign
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] o_perf_fetch_cnt,
    output logic [31:0] o_perf_flush_cnt
`endif
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned CW   = 2;

    typedef enum logic {RUN, DRAIN} state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] tag0_q, tag0_d, tag1_q, tag1_d;
    logic [CW-1:0]   inflight_q, inflight_d;
    logic [CW-1:0]   kill_q, kill_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] head_pc_q, head_pc_d, head_pc4_q, head_pc4_d;
    logic [XLEN-1:0] head_instr_q, head_instr_d;
    logic [XLEN-1:0] tail_pc_q, tail_pc_d, tail_instr_q, tail_instr_d;
    logic            vld_q, vld_d;
    logic            misalign_q, misalign_d;

    logic            pop_c, rsp_c, push_c, req_c, grant_c;
    logic [CW:0]     occ_c;

    // Next-state for PC, tag queue, FIFO, kill count and FSM.
    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        tag0_d       = tag0_q;
        tag1_d       = tag1_q;
        inflight_d   = inflight_q;
        kill_d       = kill_q;
        cnt_d        = cnt_q;
        head_pc_d    = head_pc_q;
        head_instr_d = head_instr_q;
        tail_pc_d    = tail_pc_q;
        tail_instr_d = tail_instr_q;
        misalign_d   = 1'b0;

        pop_c   = vld_q && i_instr_rdy;
        // A slot freed by this cycle's pop is reusable at once, giving 1 instr/cycle at L=1.
        occ_c   = 3'(inflight_q) + 3'(cnt_q) - 3'(pop_c);
        req_c   = !i_rst && (state_q == RUN) && (occ_c < 3'd2) && !i_pc_sel;
        grant_c = req_c && i_imem_gnt;
        rsp_c   = i_imem_rvalid && (inflight_q != '0);
        push_c  = rsp_c && (kill_q == '0) && !i_pc_sel;

        if (rsp_c) begin
            tag0_d     = tag1_q;
            inflight_d = inflight_q - 2'd1;
        end
        if (grant_c) begin
            if (inflight_d == '0) tag0_d = fetch_pc_q;
            else                  tag1_d = fetch_pc_q;
            inflight_d = inflight_d + 2'd1;
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
        if (rsp_c && (kill_q != '0)) kill_d = kill_q - 2'd1;

        if (pop_c) begin
            head_pc_d    = tail_pc_q;
            head_instr_d = tail_instr_q;
            cnt_d        = cnt_q - 2'd1;
        end
        if (push_c) begin
            if (cnt_d == '0) begin
                head_pc_d    = tag0_q;
                head_instr_d = i_imem_rdata;
            end else begin
                tail_pc_d    = tag0_q;
                tail_instr_d = i_imem_rdata;
            end
            cnt_d = cnt_d + 2'd1;
        end

        // Grant is blocked during a redirect, so inflight_d already excludes any response this cycle.
        if (i_pc_sel) begin
            cnt_d      = '0;
            kill_d     = inflight_d;
            fetch_pc_d = {i_alu_data[31:2], 2'b00};
            misalign_d = |i_alu_data[1:0];
        end
        if (cnt_d == '0) begin
            head_pc_d    = head_pc_q;
            head_instr_d = NOP_INSTR;
        end
        vld_d      = (cnt_d != '0);
        head_pc4_d = head_pc_d + 32'd4;

        case (state_q)
            RUN: begin
                if (i_pc_sel && (kill_d != '0)) state_d = DRAIN;
            end
            DRAIN: begin
                if (i_pc_sel)            state_d = (kill_d != '0) ? DRAIN : RUN;
                else if (kill_q == '0)   state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= RUN;
            fetch_pc_q   <= RESET_PC;
            tag0_q       <= '0;
            tag1_q       <= '0;
            inflight_q   <= '0;
            kill_q       <= '0;
            cnt_q        <= '0;
            head_pc_q    <= RESET_PC;
            head_pc4_q   <= RESET_PC + 32'd4;
            head_instr_q <= NOP_INSTR;
            tail_pc_q    <= '0;
            tail_instr_q <= '0;
            vld_q        <= 1'b0;
            misalign_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            tag0_q       <= tag0_d;
            tag1_q       <= tag1_d;
            inflight_q   <= inflight_d;
            kill_q       <= kill_d;
            cnt_q        <= cnt_d;
            head_pc_q    <= head_pc_d;
            head_pc4_q   <= head_pc4_d;
            head_instr_q <= head_instr_d;
            tail_pc_q    <= tail_pc_d;
            tail_instr_q <= tail_instr_d;
            vld_q        <= vld_d;
            misalign_q   <= misalign_d;
        end
    end

    assign o_imem_req  = req_c;
    assign o_imem_addr = fetch_pc_q;
    assign o_instr     = head_instr_q;
    assign o_pc        = head_pc_q;
    assign o_pc_four   = head_pc4_q;
    assign o_instr_vld = vld_q;
    assign o_misalign  = misalign_q;

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d, flush_cnt_q, flush_cnt_d;

    // Event counters: FIFO pushes and redirect pulses.
    always_comb begin
        fetch_cnt_d = fetch_cnt_q + 32'(push_c);
        flush_cnt_d = flush_cnt_q + 32'(i_pc_sel);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fetch_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign o_perf_fetch_cnt = fetch_cnt_q;
    assign o_perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch front end that produces the instruction word consumed by the decoder/control unit. It owns the program counter, issues in-order read requests to the instruction memory, and buffers up to two returned words. It delivers each word with its PC over a valid/ready handshake, and flushes on a taken branch/jump redirect driven by the control unit's `pc_sel` and the ALU target.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, fetch address loaded on reset.
- `NOP_INSTR`, 32'h0000_0013, word driven on `o_instr` while no valid instruction is presented (ADDI x0,x0,0).

Ports (one clock; reset is synchronous and active-high):
- `i_clk`  in  1  clock, all state updates on rising edge.
- `i_rst`  in  1  synchronous active-high reset.
- `i_pc_sel`  in  1  redirect request, 1-cycle pulse; sampled only when asserted.
- `i_alu_data`  in  32  redirect target address.
- `o_imem_req`  out  1  instruction memory read request.
- `o_imem_addr`  out  32  request address, word aligned.
- `i_imem_gnt`  in  1  request accepted this cycle (`o_imem_req && i_imem_gnt`).
- `i_imem_rvalid`  in  1  read data valid; responses in request order, at least 1 cycle after grant.
- `i_imem_rdata`  in  32  read data.
- `o_instr`  out  32  instruction to decoder.
- `o_pc`  out  32  PC of `o_instr`.
- `o_pc_four`  out  32  `o_pc + 4`, for the JAL/JALR writeback path.
- `o_instr_vld`  out  1  `o_instr`/`o_pc` valid.
- `i_instr_rdy`  in  1  decoder accepts; transfer when `o_instr_vld && i_instr_rdy`.
- `o_misalign`  out  1  1-cycle pulse: redirect target had `[1:0] != 0`.

## Operation
- State: `fetch_pc` (32), 2-entry FIFO of {pc, instr}, `inflight` count 0..2, `kill_cnt` 0..2, FSM {RUN, DRAIN}.
- Issue rule (RUN only): `o_imem_req = (inflight + fifo_count < 2) && !i_pc_sel`. `o_imem_addr = fetch_pc`. On grant, the request's PC is tagged into a 2-deep in-order PC queue, `fetch_pc += 4`, and `inflight++`.
- Response: when `i_imem_rvalid` and `kill_cnt == 0`, push {tagged pc, rdata} into the FIFO and decrement `inflight`. When `kill_cnt > 0`, discard the data and decrement both `kill_cnt` and `inflight`.
- Output: the FIFO head drives `o_instr`/`o_pc`/`o_pc_four`. Pop on transfer. When the FIFO is empty: `o_instr = NOP_INSTR`, `o_instr_vld = 0`, `o_pc`/`o_pc_four` hold their last values.
- Redirect (`i_pc_sel = 1`), all in the same edge:
  - FIFO cleared.
  - `kill_cnt = inflight` minus any response arriving this cycle (that response is discarded).
  - `fetch_pc = {i_alu_data[31:2], 2'b00}`.
  - `o_misalign = |i_alu_data[1:0]`.
  - Any concurrent pop is void.
  - Next state is DRAIN if the new `kill_cnt > 0`, else RUN.
- DRAIN: no requests; go to RUN in the cycle after `kill_cnt` reaches 0. A new redirect in DRAIN reloads `fetch_pc` and keeps the accumulated kill count.
- PC arithmetic is modulo 2^32: `fetch_pc` 32'hFFFF_FFFC + 4 wraps to 0; `o_pc_four` wraps the same way.

## Timing
- Reset values: `fetch_pc = RESET_PC`, FIFO empty, `inflight = kill_cnt = 0`, state RUN, `o_instr_vld = 0`, `o_instr = NOP_INSTR`, `o_pc = RESET_PC`, `o_pc_four = RESET_PC + 4`, `o_misalign = 0`. `o_imem_req = 0` while `i_rst` is high.
- Reset asserted mid-operation discards the FIFO, in-flight and kill state. Memory responses that return after reset release are ignored only if the memory is reset together with this block (system requirement).
- First request is in the first cycle after `i_rst` deasserts.
- Latency: grant at cycle T, rvalid at T+L, so `o_instr_vld` rises at T+L+1 (registered FIFO, no rvalid-to-output bypass).
- Sustained throughput: 1 instruction/cycle when L = 1 and `i_instr_rdy` is held high.
- `i_instr_rdy` low: the FIFO fills to 2, then requests stop. `o_instr` is stable while valid and not accepted.
- Push and pop in the same cycle are allowed at any occupancy permitted by the issue rule.
- Redirect penalty: with nothing in flight, the new-target request issues the cycle after the pulse and its instruction is valid at the earliest 2+L cycles after the pulse.

## Configuration
- `FETCH_PERF_EN` defined: adds output ports `o_perf_fetch_cnt` (32, counts FIFO pushes) and `o_perf_flush_cnt` (32, counts redirect pulses). Both reset to 0, wrap at 2^32, and update on the edge of the event.
- `FETCH_PERF_EN` undefined: the ports and counters are absent; all other behaviour is identical.

## Test plan
- Reset with `RESET_PC` = 32'h0000_0100, memory L = 1, rdy = 1 -> requests at 0x100, 0x104, 0x108 on consecutive cycles; first valid instr has `o_pc` 0x100, `o_pc_four` 0x104, then one instr per cycle.
- Hold `i_instr_rdy` = 0 for 5 cycles -> exactly 2 grants; `o_instr` held at the 0x100 word; no `o_imem_req` until rdy returns.
- Memory L = 3 with 2 in flight, pulse `i_pc_sel` with target 0x0000_0200 -> both stale responses dropped, DRAIN for 3 cycles, next request address 0x200, no stale instr ever valid.
- Redirect with target 0x0000_0203 -> `o_misalign` pulses for 1 cycle; fetch resumes at 0x200.
- Redirect in the same cycle as rvalid and a decoder pop -> returning word discarded, pop void, FIFO empty next cycle.
- With `FETCH_PERF_EN`, 10 fetches and 2 redirects -> `o_perf_fetch_cnt` = 10, `o_perf_flush_cnt` = 2; `i_rst` clears both.
